// File: rtl/modq_mac_pkg.sv
// Shared constants for the modular MAC datapath: default width/modulus, Barrett
// constant helper, pipeline depth and the worst-case number of final corrections.
package modq_mac_pkg;
  localparam int unsigned DEF_W      = 24;
  localparam int unsigned DEF_Q      = 16777213;
  localparam int          PIPE_DEPTH = 4;
  localparam int          N_CORR     = 2;

  function automatic logic [63:0] barrett_mu(input int unsigned w, input logic [63:0] q);
    logic [63:0] num;
    num = 64'd1 << (2 * w);
    return num / q;
  endfunction
endpackage

// File: rtl/barrett_reduce_pipe.sv
// Two-stage Barrett reduction of a 2W-bit product to [0, Q); both stages hold
// while en_i is low, so the caller's stall freezes them in lockstep with its own stages.
module barrett_reduce_pipe
  import modq_mac_pkg::*;
#(
  parameter int unsigned W = DEF_W,
  parameter int unsigned Q = DEF_Q
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           vld_i,
  input  logic           last_i,
  input  logic [2*W-1:0] p_i,
  output logic           vld_o,
  output logic           last_o,
  output logic [W-1:0]   r_o
);
  localparam logic [63:0]  Q64     = 64'(Q);
  localparam logic [63:0]  MU_FULL = barrett_mu(W, Q64);
  localparam logic [W:0]   MU      = MU_FULL[W:0];
  localparam logic [W+1:0] QX      = Q64[W+1:0];

  logic [W:0]     q1;
  logic [2*W+1:0] q1mu;
  logic [W:0]     q3_d;
  logic           s2_vld_q, s2_last_q;
  logic [W+1:0]   s2_p_q;
  logic [W:0]     s2_q3_q;
  logic [W+1:0]   r_corr;
  logic           s3_vld_q, s3_last_q;
  logic [W-1:0]   s3_r_q;

  assign q1   = p_i[2*W-1:W-1];
  assign q1mu = {{(W+1){1'b0}}, q1} * {{(W+1){1'b0}}, MU};
  assign q3_d = (W+1)'(q1mu >> (W+1));

  // The true remainder is below 3Q < 2^(W+2), so only the low W+2 bits of P and q3*Q matter.
  always_comb begin
    r_corr = s2_p_q - ({1'b0, s2_q3_q} * QX);
    for (int i = 0; i < N_CORR; i++) begin
      if (r_corr >= QX) r_corr = r_corr - QX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
    end else if (en_i) begin
      s2_vld_q  <= vld_i;
      s2_last_q <= last_i;
      s3_vld_q  <= s2_vld_q;
      s3_last_q <= s2_last_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      s2_p_q  <= p_i[W+1:0];
      s2_q3_q <= q3_d;
      s3_r_q  <= W'(r_corr);
    end
  end

  assign vld_o  = s3_vld_q;
  assign last_o = s3_last_q;
  assign r_o    = s3_r_q;
endmodule

// File: rtl/modq_mac_stream.sv
// Streamed dot product mod Q, 4 cycles from last pair to out_valid; a held result stalls
// every stage and drops in_ready. MODQ_MAC_RANGE_CHECK_EN adds the sticky range_err flag.
module modq_mac_stream
  import modq_mac_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_100Mhz,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic [CNT_W-1:0] out_len,
  output logic             range_err
);
  localparam logic [63:0] Q64 = 64'(Q);
  localparam logic [W:0]  QS  = Q64[W:0];

  logic             en;
  logic             s1_vld_q, s1_last_q;
  logic [2*W-1:0]   s1_p_q;
  logic             s3_vld, s3_last;
  logic [W-1:0]     s3_r;
  logic [W:0]       sum;
  logic [W-1:0]     sum_mod;
  logic [W-1:0]     acc_q, acc_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_len_q, out_len_d;
  logic             out_vld_q, out_vld_d;

  assign en       = !(out_vld_q && !out_ready);
  assign in_ready = en;

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
    end else if (en) begin
      s1_vld_q  <= in_valid;
      s1_last_q <= in_last;
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (en) s1_p_q <= {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
  end

  barrett_reduce_pipe #(.W(W), .Q(Q)) u_reduce (
    .clk_i  (clk_100Mhz),
    .rst_i  (rst),
    .en_i   (en),
    .vld_i  (s1_vld_q),
    .last_i (s1_last_q),
    .p_i    (s1_p_q),
    .vld_o  (s3_vld),
    .last_o (s3_last),
    .r_o    (s3_r)
  );

  // Both addends are below Q, so one conditional subtract keeps the sum reduced.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    out_len_d = out_len_q;
    out_vld_d = out_vld_q && !out_ready;
    sum       = {1'b0, acc_q} + {1'b0, s3_r};
    sum_mod   = W'((sum >= QS) ? sum - QS : sum);
    if (en && s3_vld) begin
      if (s3_last) begin
        result_d  = sum_mod;
        out_len_d = cnt_q + CNT_W'(1);
        out_vld_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = sum_mod;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      out_len_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      out_len_q <= out_len_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_valid = out_vld_q;
  assign result    = result_q;
  assign out_len   = out_len_q;

`ifdef MODQ_MAC_RANGE_CHECK_EN
  logic range_err_q;
  always_ff @(posedge clk_100Mhz) begin
    if (rst) range_err_q <= 1'b0;
    else if (in_valid && in_ready && ((in_a >= Q64[W-1:0]) || (in_b >= Q64[W-1:0])))
      range_err_q <= 1'b1;
  end
  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_modq_mac_stream.sv
// Directed bench for modq_mac_stream: reference model pushes expected vector results,
// a negedge monitor pops and compares them on every output handshake.
module tb_modq_mac_stream;
  import modq_mac_pkg::*;

  localparam int     W     = 24;
  localparam int     CNT_W = 16;
  localparam longint QL    = 16777213;

  typedef struct {
    longint res;
    longint len;
  } exp_t;

  logic             clk_100Mhz = 1'b0;
  logic             rst, in_valid, in_last, out_ready;
  logic             in_ready, out_valid, range_err;
  logic [W-1:0]     in_a, in_b, result;
  logic [CNT_W-1:0] out_len;

  exp_t   sb[$];
  int     hs_cyc[$];
  int     nchk = 0;
  int     nfail = 0;
  int     cyc = 0;
  longint m_acc = 0;
  longint m_len = 0;

  always #5 clk_100Mhz = ~clk_100Mhz;
  always @(posedge clk_100Mhz) cyc <= cyc + 1;

  modq_mac_stream dut (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_len    (out_len),
    .range_err  (range_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output side: every handshake must match the oldest outstanding expected vector.
  always @(negedge clk_100Mhz) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nchk++;
        nfail++;
        $error("FAIL unexpected_output: observed result %0d, no vector outstanding", result);
      end else begin
        e = sb.pop_front();
        check("result", {40'd0, result}, e.res);
        check("out_len", {48'd0, out_len}, e.len);
        hs_cyc.push_back(cyc);
      end
    end
  end

  // Called and returns 2ns after a rising edge; returns just after the accepting edge.
  task automatic send(input longint a, input longint b, input bit last);
    bit rdy;
    int n;
    in_valid = 1'b1;
    in_a     = a[W-1:0];
    in_b     = b[W-1:0];
    in_last  = last;
    n = 0;
    do begin
      @(negedge clk_100Mhz);
      rdy = in_ready;
      @(posedge clk_100Mhz);
      #2;
      n++;
    end while (!rdy && n < 200);
    check("send_accepted", {63'd0, rdy}, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_acc = (m_acc + (a * b) % QL) % QL;
    m_len++;
    if (last) begin
      sb.push_back('{res: m_acc, len: m_len % 65536});
      m_acc = 0;
      m_len = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk_100Mhz);
      #2;
      n++;
    end
    check("drain_empty", sb.size(), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk_100Mhz);
    #2;
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {40'd0, result}, 64'd0);
    check("rst_out_len", {48'd0, out_len}, 64'd0);
    check("rst_range_err", {63'd0, range_err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single pair: the acceptance cycle counts as cycle 1.
    send(2, 3, 1'b1);
    lat = 1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk_100Mhz);
      #2;
      lat++;
      n++;
    end
    check("t1_latency", lat, PIPE_DEPTH);
    check("t1_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk_100Mhz);
    #2;
    check("t1_one_cycle", {63'd0, out_valid}, 64'd0);
    drain();

    for (int i = 0; i < 4; i++) send(QL - 1, QL - 1, i == 3);
    drain();

    send(QL - 1, 1, 1'b0);
    send(QL - 1, 1, 1'b1);
    send(5, 7, 1'b1);
    drain();
    check("t3_back_to_back", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 64'd1);

    out_ready = 1'b0;
    send(1, 1, 1'b1);
    send(1, 1, 1'b0);
    send(2, 2, 1'b1);
    repeat (5) @(posedge clk_100Mhz);
    #2;
    for (int i = 0; i < 3; i++) begin
      check("t4_held_valid", {63'd0, out_valid}, 64'd1);
      check("t4_held_result", {40'd0, result}, 64'd1);
      check("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
      @(posedge clk_100Mhz);
      #2;
    end
    check("t4_pending", sb.size(), 64'd2);
    out_ready = 1'b1;
    drain();

    send(9, 9, 1'b0);
    send(3, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk_100Mhz);
    #2;
    rst = 1'b0;
    m_acc = 0;
    m_len = 0;
    check("t5_rst_result", {40'd0, result}, 64'd0);
    check("t5_rst_out_valid", {63'd0, out_valid}, 64'd0);
    send(4, 4, 1'b1);
    drain();

    check("t6_range_err_before", {63'd0, range_err}, 64'd0);
    send(QL, 1, 1'b1);
`ifdef MODQ_MAC_RANGE_CHECK_EN
    check("t6_range_err_set", {63'd0, range_err}, 64'd1);
    repeat (4) @(posedge clk_100Mhz);
    #2;
    check("t6_range_err_held", {63'd0, range_err}, 64'd1);
`else
    check("t6_range_err_tied", {63'd0, range_err}, 64'd0);
    repeat (4) @(posedge clk_100Mhz);
    #2;
    check("t6_range_err_still", {63'd0, range_err}, 64'd0);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
